// File: rtl/clk_div_param_if.sv
// clk_div_param_if: control/status bundle of the programmable clock divider.
// master drives enable, ratio and load; slave returns ack, divided clock, pulse.
interface clk_div_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_clk_en;
  logic [WIDTH-1:0] i_div_ratio;
  logic             i_ratio_load;
  logic             o_ratio_ack;
  logic             o_div_clk;
  logic             o_div_pulse;

  modport master (
    output i_clk_en,
    output i_div_ratio,
    output i_ratio_load,
    input  o_ratio_ack,
    input  o_div_clk,
    input  o_div_pulse
  );

  modport slave (
    input  i_clk_en,
    input  i_div_ratio,
    input  i_ratio_load,
    output o_ratio_ack,
    output o_div_clk,
    output o_div_pulse
  );
endinterface

// File: rtl/clk_div_param.sv
// clk_div_param: integer clock divider with glitch-free ratio reload.
// Ports: i_ref_clk, i_rst_n (async, low), bus (slave: en/ratio/load in; ack/clk/pulse out).
module clk_div_param #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RESET_RATIO   = 2,
  parameter bit          ODD_HIGH_LONG = 1'b0
) (
  input  logic            i_ref_clk,
  input  logic            i_rst_n,
  clk_div_param_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pv_q, pv_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dq_q, dq_d;
  logic             pulse_q, pulse_d;
  logic             ack_q, ack_d;

  logic             go;
  logic             wrap;
  logic             apply;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] cnt_nxt;

  assign go   = bus.i_clk_en && (act_q >= WIDTH'(2));
  // high phase length; the extra half cycle goes high only when asked
  assign hi   = (act_q >> 1)
              + WIDTH'(ODD_HIGH_LONG && act_q[0]);
  assign wrap = (cnt_q == act_q - 1'b1);
  assign cnt_nxt = wrap ? '0 : cnt_q + 1'b1;
  // ratio may only change on a period boundary or while idle
  assign apply = (state_q == S_IDLE) || (go && wrap);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    pulse_d = 1'b0;
    act_d   = act_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    ack_d   = 1'b0;

    unique case (1'b1)
      !go: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        dq_d    = 1'b0;
        pulse_d = 1'b0;
      end
      go && (state_q == S_IDLE): begin
        state_d = S_RUN;
        cnt_d   = '0;
        dq_d    = 1'b1;
        pulse_d = 1'b1;
      end
      go && (state_q == S_RUN): begin
        cnt_d   = cnt_nxt;
        dq_d    = (cnt_nxt < hi);
        pulse_d = (cnt_nxt == '0);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // a load landing on an apply point bypasses the pending slot
    if (bus.i_ratio_load) begin
      pend_d = bus.i_div_ratio;
      if (apply) begin
        act_d = bus.i_div_ratio;
        pv_d  = 1'b0;
        ack_d = 1'b1;
      end else begin
        pv_d  = 1'b1;
      end
    end else if (apply && pv_q) begin
      act_d = pend_q;
      pv_d  = 1'b0;
      ack_d = 1'b1;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      act_q   <= WIDTH'(RESET_RATIO);
      pend_q  <= '0;
      pv_q    <= 1'b0;
      cnt_q   <= '0;
      dq_q    <= 1'b0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
    end
  end

  // bypass passes the reference clock straight through
  assign bus.o_div_clk   = (go && (state_q == S_RUN)) ? dq_q : i_ref_clk;
  assign bus.o_div_pulse = pulse_q;
  assign bus.o_ratio_ack = ack_q;

endmodule

// File: tb/tb_clk_div_param.sv
// tb_clk_div_param: random + directed bench with a period-schedule model.
// Model queues each period's waveform and reloads the ratio when it drains.
module tb_clk_div_param;

  localparam int unsigned W   = 8;
  localparam int unsigned RR  = 2;
  localparam bit          OHL = 1'b0;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] ratio;
  logic         load;

  int checks   = 0;
  int failures = 0;

  clk_div_param_if #(.WIDTH(W)) bus ();

  assign bus.i_clk_en     = en;
  assign bus.i_div_ratio  = ratio;
  assign bus.i_ratio_load = load;

  clk_div_param #(
    .WIDTH(W),
    .RESET_RATIO(RR),
    .ODD_HIGH_LONG(OHL)
  ) dut (
    .i_ref_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int       m_act;
  int       m_pend;
  bit       m_pv, m_run, m_dq, m_pulse, m_ack;
  bit [1:0] wave[$];

  function automatic int hi_of(int a);
    return OHL ? (a + 1) / 2 : a / 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit go;
    bit bnd;
    if (!rst_n) begin
      m_act = RR; m_pend = 0; m_pv = 0; m_run = 0;
      m_dq = 0; m_pulse = 0; m_ack = 0;
      wave.delete();
    end else begin
      go  = en && (m_act >= 2);
      bnd = !m_run || (go && wave.size() == 0);
      m_ack = 0;
      if (load) begin
        if (bnd) begin
          m_act = int'(ratio); m_pv = 0; m_ack = 1;
        end else begin
          m_pend = int'(ratio); m_pv = 1;
        end
      end else if (bnd && m_pv) begin
        m_act = m_pend; m_pv = 0; m_ack = 1;
      end
      if (!go) begin
        m_run = 0; m_dq = 0; m_pulse = 0;
        wave.delete();
      end else if (!m_run || wave.size() == 0) begin
        m_run = 1; m_dq = 1; m_pulse = 1;
        wave.delete();
        for (int k = 1; k < m_act; k++)
          wave.push_back({bit'(k < hi_of(m_act)), 1'b0});
      end else begin
        {m_dq, m_pulse} = wave.pop_front();
      end
    end
  end

  task automatic chk(string nm, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- compare + measurement ----------------
  int cyc = 0;
  int last_p = 0;
  int interval = 0;
  int hc = 0;
  int hi_last = 0;
  int ack_cnt = 0;

  always @(posedge clk or negedge clk or negedge rst_n) begin : cmp
    logic exp_clk;
    #1;
    exp_clk = (en && m_act >= 2 && m_run) ? m_dq : clk;
    chk("div_clk", bus.o_div_clk, exp_clk);
    chk("div_pulse", bus.o_div_pulse, m_pulse);
    chk("ratio_ack", bus.o_ratio_ack, m_ack);
    if (clk && rst_n) begin
      cyc++;
      if (bus.o_ratio_ack) ack_cnt++;
      if (bus.o_div_pulse) begin
        interval = cyc - last_p;
        last_p   = cyc;
        hi_last  = hc;
        hc       = 0;
      end
    end
    if (!clk && bus.o_div_clk) hc++;
  end

  // ---------------- stimulus ----------------
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(int v);
    ratio = W'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_pulse(string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_div_pulse) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: got no pulse expected pulse within 40 cycles", nm);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ratio = '0; load = 1'b0;
    #1;
    chk("rst_pulse", bus.o_div_pulse, 1'b0);
    chk("rst_ack", bus.o_ratio_ack, 1'b0);
    cycles(3);
    rst_n = 1'b1;
    en    = 1'b1;

    // default ratio 2
    cycles(20);
    chk_int("n2_period", interval, 2);
    chk_int("n2_high", hi_last, 1);

    // load 5 mid-period
    @(posedge clk); @(negedge clk);
    ack_cnt = 0;
    do_load(5);
    cycles(30);
    chk_int("n5_period", interval, 5);
    chk_int("n5_high", hi_last, 2);
    chk_int("n5_acks", ack_cnt, 1);

    // 7 then 9 inside one period, only 9 applies
    wait_pulse("wait_n5");
    ack_cnt = 0;
    do_load(7);
    do_load(9);
    cycles(40);
    chk_int("n9_period", interval, 9);
    chk_int("n9_high", hi_last, 4);
    chk_int("n9_acks", ack_cnt, 1);

    // ratio 1 forces bypass, then 4
    do_load(1);
    cycles(12);
    @(posedge clk); #2;
    chk("n1_bypass_hi", bus.o_div_clk, 1'b1);
    @(negedge clk); #2;
    chk("n1_bypass_lo", bus.o_div_clk, 1'b0);
    @(negedge clk);
    do_load(4);
    cycles(20);
    chk_int("n4_period", interval, 4);
    chk_int("n4_high", hi_last, 2);

    // drop enable at CNT=2 of N=6
    do_load(6);
    cycles(20);
    wait_pulse("wait_n6");
    cycles(2);
    en = 1'b0;
    #2;
    chk("en_drop_bypass", bus.o_div_clk, 1'b0);
    cycles(3);
    en = 1'b1;
    #2;
    chk("pre_start_bypass", bus.o_div_clk, 1'b0);
    @(posedge clk); #2;
    chk("restart_pulse", bus.o_div_pulse, 1'b1);
    @(negedge clk); #2;
    chk("restart_high", bus.o_div_clk, 1'b1);
    cycles(20);
    chk_int("n6_period", interval, 6);
    chk_int("n6_high", hi_last, 3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      en    = ($urandom_range(0, 15) != 0);
      load  = ($urandom_range(0, 7) == 0);
      ratio = W'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    load = 1'b0; rst_n = 1'b1; en = 1'b1;

    // maximum ratio
    do_load(255);
    cycles(800);
    chk_int("n255_period", interval, 255);
    chk_int("n255_high", hi_last, 127);

    // async reset while the divided clock is high
    begin : find_high
      bit hit;
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
        @(negedge clk); #1;
        if (bus.o_div_clk) hit = 1;
      end
      chk("n255_found_high", hit, 1'b1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_div_clk", bus.o_div_clk, 1'b0);
    chk("arst_pulse", bus.o_div_pulse, 1'b0);
    chk("arst_ack", bus.o_ratio_ack, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk_int("post_rst_period", interval, 2);
    chk_int("post_rst_high", hi_last, 1);

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_param.md
CLK_DIV_PARAM -- requirements
Module: clk_div_param

Interface
REQ-001 Parameter WIDTH, default 8: width of the ratio bus and the period counter; legal range 2..16.
REQ-002 Parameter RESET_RATIO, default 2: active divide ratio after reset; legal range 2..2^WIDTH-1.
REQ-003 Parameter ODD_HIGH_LONG, default 0: for odd ratios, 0 selects a shorter high phase and 1 selects a longer high phase.
REQ-004 i_ref_clk  in  1  reference clock; all state is rising-edge triggered.
REQ-005 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-006 i_clk_en  in  1  divider enable; when low, the block is in bypass.
REQ-007 i_div_ratio  in  WIDTH  requested divide ratio N; sampled only when i_ratio_load is high.
REQ-008 i_ratio_load  in  1  single-cycle request to capture i_div_ratio as the pending ratio.
REQ-009 o_ratio_ack  out  1  one-cycle registered strobe, high on the cycle after a new ratio becomes active.
REQ-010 o_div_clk  out  1  divided clock, or i_ref_clk when the block is in bypass.
REQ-011 o_div_pulse  out  1  registered one-ref-cycle strobe marking each divided-clock rising edge.

Function
REQ-012 Internal state: active ratio ACT (WIDTH bits); pending ratio PEND plus a valid flag PV; period counter CNT (WIDTH bits); divided-clock register DQ; run flag RUN.
REQ-013 Define GO = i_clk_en && (ACT >= 2) and HI = ODD_HIGH_LONG ? ceil(ACT/2) : floor(ACT/2).
REQ-014 o_div_clk SHALL equal DQ when GO && RUN, and SHALL equal i_ref_clk otherwise, through a combinational mux.
REQ-015 On an edge with GO low (BYPASS state): RUN, CNT, DQ and o_div_pulse go to 0.
REQ-016 On an edge with GO high and RUN low (START transition):
- RUN<=1, CNT<=0, DQ<=1, o_div_pulse<=1.
- The first divided period therefore starts high, one cycle after the condition.
REQ-017 On an edge with GO and RUN both high (RUN state):
- CNT_NEXT = (CNT == ACT-1) ? 0 : CNT+1.
- CNT<=CNT_NEXT; DQ<=(CNT_NEXT < HI); o_div_pulse<=(CNT_NEXT == 0).
REQ-018 The divided period SHALL be exactly ACT ref cycles, with the high phase HI cycles and the low phase ACT-HI cycles.
- Example: N=5 with ODD_HIGH_LONG=0 gives 2 cycles high and 3 cycles low.
REQ-019 An i_ratio_load edge SHALL set PEND<=i_div_ratio and PV<=1; a later load before the ratio is applied overwrites PEND (last value wins).
REQ-020 Apply point: an edge in RUN with CNT_NEXT == 0, or any edge while RUN is low.
REQ-021 At the apply point with PV high:
- ACT<=PEND, PV<=0, o_ratio_ack<=1.
- The new period, including its HI value, uses the new ACT starting from CNT=0.
REQ-022 If i_ratio_load coincides with an apply point, i_div_ratio SHALL be applied directly; o_ratio_ack pulses and PV ends at 0.
REQ-023 A loaded ratio of 0 or 1 SHALL be applied normally and then force bypass (GO low) until a ratio >= 2 is applied.
REQ-024 ACT SHALL never change mid-period while in RUN, so no divided-clock phase is ever truncated or stretched.
REQ-025 Deassertion of i_clk_en mid-period SHALL enter bypass on the same cycle and abort the period; reassertion SHALL restart at START.
REQ-026 CNT comparisons SHALL be WIDTH-bit unsigned with no overflow; ACT=2^WIDTH-1 SHALL be supported.

Reset
REQ-027 Asynchronous reset SHALL set: ACT=RESET_RATIO, PEND=0, PV=0, CNT=0, DQ=0, RUN=0, o_div_pulse=0, o_ratio_ack=0.
- o_div_clk follows i_ref_clk during reset (RUN=0).
REQ-028 Reset asserted mid-period or with a load pending SHALL discard PEND; RESET_RATIO becomes active after release.

Verification
REQ-029 WIDTH=8, reset released, i_clk_en=1, no load -> o_div_clk period 2 with 1 cycle high; o_div_pulse fires every 2 cycles.
REQ-030 Load N=5 at mid-period with ODD_HIGH_LONG=0 -> current 2-cycle period completes unchanged, then periods of 5 cycles (2 high, 3 low); o_ratio_ack goes high once, one cycle after the apply point.
REQ-031 Loads of 7 then 9 within one period -> only 9 is applied; o_ratio_ack pulses exactly once.
REQ-032 Load N=1 -> o_div_clk equals i_ref_clk after the apply point; then load N=4 -> START, then a 4-cycle period with 2 cycles high.
REQ-033 i_clk_en dropped at CNT=2 of N=6 -> o_div_clk follows i_ref_clk the same cycle; re-enable -> first divided-clock high one cycle later, CNT restarts at 0.
REQ-034 WIDTH=8, N=255 -> period 255 with 127 cycles high; reset asserted mid-period -> all outputs return to reset values immediately.
